// File: rtl/sum_pkg.sv
// Shared types and default widths for the window accumulator.
package sum_pkg;

  localparam int unsigned SUM_DATA_W = 128;
  localparam int unsigned SUM_ACC_W  = 136;
  localparam int unsigned SUM_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  typedef logic [SUM_DATA_W-1:0] sum_t;

endpackage

// File: rtl/sum_acc_core.sv
// Accumulator register with zero-extending adder and a sticky carry-out flag.
module sum_acc_core #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ACC_W  = 136
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_add,
  output logic [ACC_W-1:0]  o_acc,
  output logic              o_ovf
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;

  // One extra bit on the adder captures the carry out of ACC_W.
  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(i_add);

  // Clear wins over enable; ovf only ever sets until the next clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en) begin
      r_acc <= w_sum[ACC_W-1:0];
      r_ovf <= r_ovf | w_sum[ACC_W];
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/sum_window_acc.sv
// Folds a programmable number of incoming sums into one window total.
module sum_window_acc
  import sum_pkg::*;
#(
  parameter int unsigned DATA_W = SUM_DATA_W,
  parameter int unsigned ACC_W  = SUM_ACC_W,
  parameter int unsigned CNT_W  = SUM_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  win_len,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start_ok;
  logic             w_accept;
  logic             w_last;
  logic             w_clr;

  assign w_start_ok = (r_state == IDLE) && start && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt + CNT_W'(1)) == r_len;
  assign w_clr      = flush || w_start_ok;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; flush overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (win_len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        in_ready = !flush;
        busy     = 1'b1;
        if (w_accept && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      out_valid   = 1'b0;
    end
  end

  // Window length latch and beat counter; count stays visible after the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_len <= win_len;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  sum_acc_core #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(w_clr),
    .i_en (w_accept),
    .i_add(in_data),
    .o_acc(out_acc),
    .o_ovf(out_ovf)
  );

  assign out_count = r_cnt;

endmodule

// File: tb/tb_sum_window_acc.sv
module tb_sum_window_acc;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 129;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] win_len;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_count;
  logic          out_ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: exact unbounded-ish total of accepted beats.
  logic [255:0] m_total;
  logic [DW-1:0] q[$];

  sum_window_acc #(
    .DATA_W(DW),
    .ACC_W (AW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .win_len  (win_len),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_count(out_count),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive beats from q until len are accepted; ready is expected high throughout ACC.
  task automatic feed(input int unsigned len, input bit gaps, input bit noise);
    int unsigned got;
    int unsigned budget;
    got = 0;
    budget = 0;
    while (got < len && budget < 3000) begin
      if (!gaps || $urandom_range(1, 0) == 1) begin
        in_valid = 1'b1;
        in_data  = q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = rand128();
      end
      if (noise) begin
        start   = $urandom_range(1, 0) == 1;
        win_len = CW'($urandom);
      end
      chk("in_ready_acc", in_ready, 1);
      if (in_valid) begin
        m_total = m_total + q[0];
        void'(q.pop_front());
        got++;
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("feed_done", got, len);
  endtask

  // Check the HOLD result, apply backpressure, then release it.
  task automatic check_result(input int unsigned len, input int unsigned bp);
    logic [AW-1:0] e_acc;
    logic          e_ovf;
    e_acc = m_total[AW-1:0];
    e_ovf = (m_total >> AW) != 0;
    chk("hold_valid", out_valid, 1);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_busy", busy, 1);
    chk("hold_acc", out_acc, e_acc);
    chk("hold_count", out_count, len);
    chk("hold_ovf", out_ovf, e_ovf);
    for (int i = 0; i < int'(bp); i++) begin
      out_ready = 1'b0;
      start     = $urandom_range(1, 0) == 1;
      win_len   = CW'($urandom);
      in_valid  = $urandom_range(1, 0) == 1;
      in_data   = rand128();
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_acc", out_acc, e_acc);
      chk("bp_count", out_count, len);
      chk("bp_ovf", out_ovf, e_ovf);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_valid", out_valid, 0);
    chk("rel_busy", busy, 0);
    chk("idle_acc", out_acc, e_acc);
    chk("idle_count", out_count, len);
    chk("idle_ovf", out_ovf, e_ovf);
  endtask

  task automatic run_window(input int unsigned len, input bit gaps, input bit noise,
                            input int unsigned bp);
    m_total = '0;
    start   = 1'b1;
    win_len = CW'(len);
    tick();
    start   = 1'b0;
    win_len = CW'($urandom);
    chk("win_busy", busy, 1);
    feed(len, gaps, noise);
    check_result(len, bp);
  endtask

  initial begin
    int unsigned n;
    rst_n     = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Basic two-beat window.
    q = {};
    q.push_back(DW'(25));
    q.push_back(DW'(70));
    run_window(2, 0, 0, 0);
    chk("basic_sum", out_acc, 95);

    // Wrap with sticky overflow: 3 * (2^128-1) mod 2^129.
    q = {};
    repeat (3) q.push_back('1);
    run_window(3, 0, 0, 0);

    // Backpressure in HOLD for five cycles.
    q = {};
    q.push_back(rand128());
    q.push_back(rand128());
    run_window(2, 0, 0, 5);

    // Random gaps on in_valid with a 4-beat window.
    q = {};
    repeat (4) q.push_back(rand128());
    run_window(4, 1, 1, 2);

    // Zero-length window goes straight to HOLD.
    q = {};
    run_window(0, 0, 0, 1);

    // Flush after one of three beats.
    q = {};
    q.push_back(DW'(10));
    m_total = '0;
    start   = 1'b1;
    win_len = CW'(3);
    tick();
    start = 1'b0;
    feed(1, 0, 0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(99);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_valid", out_valid, 0);
      chk("flush_busy", busy, 0);
      tick();
    end
    chk("flush_acc", out_acc, 0);
    chk("flush_count", out_count, 0);
    chk("flush_ovf", out_ovf, 0);

    // Flush and start together: start loses.
    flush   = 1'b1;
    start   = 1'b1;
    win_len = CW'(5);
    tick();
    flush = 1'b0;
    start = 1'b0;
    chk("flush_start_busy", busy, 0);

    // Flush while in HOLD drops the result.
    start   = 1'b1;
    win_len = '0;
    tick();
    start = 1'b0;
    chk("hold0_valid", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_hold_valid", out_valid, 0);
    chk("flush_hold_busy", busy, 0);

    q = {};
    q.push_back(DW'(15));
    run_window(1, 0, 0, 0);
    chk("after_flush_sum", out_acc, 15);

    // Asynchronous reset mid-window.
    q = {};
    repeat (3) q.push_back(rand128());
    m_total = '0;
    start   = 1'b1;
    win_len = CW'(3);
    tick();
    start = 1'b0;
    feed(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_acc", out_acc, 0);
    chk("arst_count", out_count, 0);
    chk("arst_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_idle_valid", out_valid, 0);

    // Randomised windows with gaps, mid-window start noise and backpressure.
    for (int w = 0; w < 8; w++) begin
      n = $urandom_range(8, 1);
      q = {};
      repeat (n) q.push_back(rand128());
      run_window(n, 1, 1, $urandom_range(3, 0));
    end

    // Maximum-length window.
    q = {};
    repeat (255) q.push_back(rand128());
    run_window(255, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_window_acc.md
Name: sum_window_acc

Overview:
- Downstream consumer of the operand-sum stage: accepts a stream of 128-bit sums (c = a + b) over valid/ready and accumulates a programmable number of them into one wider total.
- Reports the total, the beat count and a sticky overflow flag once per window, over a valid/ready output; used to fold per-sample sums into window totals for checking/logging.

Parameters:
DATA_W, 128, width of each incoming sum
ACC_W, 136, accumulator width (must be >= DATA_W)
CNT_W, 8, width of window length and beat counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a window (honoured only in IDLE)
win_len  input  CNT_W  number of beats in the window; sampled on accepted start
flush  input  1  synchronous abort; returns to IDLE, discards partial total
in_valid  input  1  upstream sum valid
in_ready  output  1  block accepts a sum this cycle
in_data  input  DATA_W  incoming sum, unsigned
out_valid  output  1  window result available
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  accumulated total, modulo 2^ACC_W
out_count  output  CNT_W  beats accumulated
out_ovf  output  1  sticky: carry out of ACC_W occurred in this window
busy  output  1  high in ACC or HOLD

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). All state is reset asynchronously.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_acc=0, out_count=0, out_ovf=0, busy=0, internal len/cnt=0.
- States: IDLE, ACC, HOLD.

IDLE:
- start=1 latches win_len, clears acc/cnt/ovf.
- Next state is ACC if win_len != 0.
- Next state is HOLD directly if win_len == 0 (result acc=0, count=0, ovf=0).

ACC:
- in_ready=1.
- On in_valid & in_ready: acc <= acc + zero-extend(in_data) truncated to ACC_W; ovf <= ovf | carry-out; cnt <= cnt+1.
- When the accepted beat makes cnt == len, next state is HOLD.
- in_valid low stalls without change.

HOLD:
- out_valid=1, in_ready=0.
- out_acc/out_count/out_ovf are registered and held stable while out_valid & !out_ready.
- On out_ready, next state is IDLE and out_valid drops the following cycle.
- Outputs keep their last values in IDLE.

Latency:
- Last beat accepted at cycle N gives out_valid=1 at cycle N+1.
- Minimum window turnaround is start, len beats, one HOLD cycle, then back to IDLE (next start honoured the cycle after returning).

Rules and boundary conditions:
- start outside IDLE is ignored; win_len is not re-sampled mid-window.
- flush has priority over every other event in every state: next state is IDLE, out_valid=0, acc/cnt/ovf cleared; flush and start in the same cycle means flush wins and start is ignored.
- in_valid while not in ACC is not accepted (in_ready=0); upstream must hold its data.
- Maximum window is 2^CNT_W-1 beats.
- Wrap-around: acc wraps modulo 2^ACC_W and ovf latches; ovf never clears before the next start or flush.
- Asynchronous reset mid-window discards all state immediately.
- in_data is treated as unsigned; no signed interpretation.

Decomposition:
- Shared package sum_pkg:
  - typedef enum state_t {IDLE, ACC, HOLD}
  - DATA_W/ACC_W default constants
  - typedef sum_t logic [DATA_W-1:0]
- One natural sub-module: sum_acc_core, the accumulator register plus adder with carry-out, clear and enable; FSM and handshakes stay in the top.

Test Plan:
1. Basic two-beat window: win_len=2, send 25 then 70 -> out_valid one cycle after second beat; out_acc=95, out_count=2, out_ovf=0.
2. Overflow with ACC_W=129: win_len=3, three beats of 2^128-1 -> out_acc=2^128-3, out_count=3, out_ovf=1.
3. Backpressure and stalls:
   - Hold out_ready=0 for 5 cycles in HOLD -> out_valid and outputs stable, in_ready=0, start ignored; result drops one cycle after out_ready=1.
   - Toggle in_valid randomly with win_len=4 -> total equals sum of accepted beats only.
4. Zero-length window: win_len=0 -> HOLD next cycle, out_acc=0, out_count=0, no beats consumed.
5. Abort and reset:
   - flush after 1 of 3 beats (data 10) -> IDLE, out_valid never asserted; next window win_len=1, data 15 gives out_acc=15.
   - rst_n low mid-window -> all outputs at reset values asynchronously.
